// File: rtl/if_fetch_queue_if.sv
// IF -> ID fetch queue bundle: push side from fetch, head/stall/flush side toward decode.
interface if_fetch_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                  in_valid;
  logic [PC_WIDTH-1:0]   PC_in;
  logic [INST_WIDTH-1:0] Instruction_in;
  logic                  in_ready;
  logic                  freeze;
  logic                  Flush;
  logic                  out_valid;
  logic [PC_WIDTH-1:0]   PC;
  logic [INST_WIDTH-1:0] Instruction;
  logic [CNT_WIDTH-1:0]  count;
  logic                  overflow;

  modport master (
    output in_valid, PC_in, Instruction_in, freeze, Flush,
    input  in_ready, out_valid, PC, Instruction, count, overflow
  );

  modport slave (
    input  in_valid, PC_in, Instruction_in, freeze, Flush,
    output in_ready, out_valid, PC, Instruction, count, overflow
  );
endinterface

// File: rtl/if_fetch_queue.sv
// DEPTH-entry first-word-fall-through queue of {PC, Instruction} pairs between IF and ID,
// with freeze (ID stall), Flush (redirect), backpressure, occupancy and sticky overflow.
module if_fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic           clk,
  input logic           rst,
  if_fetch_queue_if.slave q
);
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem_d   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_d [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic out_valid;
  logic pop;
  logic in_ready;
  logic push;

  always_comb begin
    out_valid = (count_q != '0);
    pop       = out_valid & ~q.freeze;
    in_ready  = (count_q != CNT_WIDTH'(DEPTH)) | pop;
    push      = q.in_valid & in_ready;
  end

  // Flush outranks push/pop: pointers and count restart from zero and the write is dropped.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (q.Flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = q.PC_in;
        inst_mem_d[wr_ptr_q] = q.Instruction_in;
        wr_ptr_d             = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      if (q.in_valid & ~in_ready) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage carries no reset; the head is gated whenever the queue is empty.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

  always_comb begin
    q.in_ready    = in_ready;
    q.out_valid   = out_valid;
    q.PC          = out_valid ? pc_mem_q[rd_ptr_q] : '0;
    q.Instruction = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    q.count       = count_q;
    q.overflow    = overflow_q;
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=4): fill, push/pop at full, overflow, flush, wrap, async reset.
module tb_if_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue_if #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) bus ();

  if_fetch_queue #(.PC_WIDTH(32), .INST_WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc);
    bus.in_valid       = 1'b1;
    bus.PC_in          = pc;
    bus.Instruction_in = ins(pc);
  endtask

  task automatic head(input string tag, input int cnt, input logic [31:0] pc);
    chk({tag, "_count"}, 64'(bus.count), 64'(cnt));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(cnt != 0));
    chk({tag, "_pc"}, 64'(bus.PC), (cnt != 0) ? 64'(pc) : 64'd0);
    chk({tag, "_inst"}, 64'(bus.Instruction), (cnt != 0) ? 64'(ins(pc)) : 64'd0);
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.PC_in          = '0;
    bus.Instruction_in = '0;
    bus.freeze         = 1'b0;
    bus.Flush          = 1'b0;

    #12;
    head("reset", 0, 32'h0);
    chk("reset_ready", 64'(bus.in_ready), 64'd1);
    chk("reset_ovf", 64'(bus.overflow), 64'd0);
    rst = 1'b0;
    tick();

    // Fill with ID frozen
    bus.freeze = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'(4 * k));
      tick();
      head($sformatf("fill%0d", k), k + 1, 32'h00);
    end
    chk("full_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;

    // Push and pop together while full
    bus.freeze = 1'b0;
    drive(32'h10);
    #1;
    chk("fullpp_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    head("fullpp", 4, 32'h04);
    chk("fullpp_ovf", 64'(bus.overflow), 64'd0);
    tick();
    head("drain1", 3, 32'h08);
    tick();
    head("drain2", 2, 32'h0C);
    tick();
    head("drain3", 1, 32'h10);
    bus.freeze = 1'b1;
    tick();
    head("frozen", 1, 32'h10);

    // Refill, then overflow
    drive(32'h14); tick();
    drive(32'h18); tick();
    drive(32'h1C); tick();
    bus.in_valid = 1'b0;
    head("refill", 4, 32'h10);
    drive(32'h20);
    #1;
    chk("ovf_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    head("ovf_hold", 4, 32'h10);
    bus.freeze = 1'b0;
    tick();
    bus.freeze = 1'b1;
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);
    head("ovf_pop", 3, 32'h14);
    bus.Flush = 1'b1;
    tick();
    bus.Flush = 1'b0;
    chk("flush_ovf", 64'(bus.overflow), 64'd0);
    head("flush", 0, 32'h0);

    // Flush with concurrent push
    drive(32'h30); tick();
    drive(32'h34); tick();
    bus.in_valid = 1'b0;
    head("pre_flush", 2, 32'h30);
    bus.Flush = 1'b1;
    drive(32'h20);
    #1;
    chk("flush_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.Flush = 1'b0;
    bus.in_valid = 1'b0;
    head("flushpush", 0, 32'h0);
    drive(32'h24);
    #1;
    chk("nobypass", 64'(bus.out_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    head("after_flush", 1, 32'h24);

    // Streaming across pointer wrap
    bus.freeze = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(32'h100 + 32'(4 * i));
      tick();
      head($sformatf("wrap%0d", i), 1, 32'h100 + 32'(4 * i));
    end
    bus.in_valid = 1'b0;
    tick();
    head("wrap_end", 0, 32'h0);

    // Async reset between edges
    bus.freeze = 1'b1;
    drive(32'h200); tick();
    drive(32'h204); tick();
    drive(32'h208); tick();
    bus.in_valid = 1'b0;
    head("pre_rst", 3, 32'h200);
    #2;
    rst = 1'b1;
    #1;
    head("async_rst", 0, 32'h0);
    chk("async_rst_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;
    tick();
    drive(32'h300);
    tick();
    bus.in_valid = 1'b0;
    head("post_rst", 1, 32'h300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
